// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with load handshake and back-to-back words
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shifting, last, accept;

    always_comb begin
        shifting = state_q == SHIFT;
        last     = shifting && cnt_q == LAST;
        ready    = !shifting || last;
        accept   = load && ready;
        shifted  = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        state_d  = accept ? SHIFT : (last ? IDLE : state_q);
        sreg_d   = accept ? din : (shifting ? shifted : sreg_q);
        cnt_d    = (accept || last) ? '0 : (shifting ? cnt_q + 1'b1 : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure decodes of the registered state, so IDLE always shows zeros.
    assign q       = shifting && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign q_valid = shifting;
    assign done    = last;
endmodule
